// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory lane controller.
// Optional misalignment trapping is selected in the top by DMEM_MISALIGN_TRAP_EN.
package dmem_pkg;

    localparam int LANES     = 4;
    localparam int DEF_ROW_W = 14;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2,
        RESP = 2'd3
    } state_e;

    // Number of bytes moved by an access; 0 marks the illegal encoding.
    function automatic logic [2:0] size_bytes(input size_e sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Sign/zero extension of the assembled load word; byte 0 of the access sits in bits [7:0].
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] asm_word,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    always_comb begin
        rdata = '0;
        case (size)
            SZ_BYTE: rdata = {{24{~is_unsigned & asm_word[7]}}, asm_word[7:0]};
            SZ_HALF: rdata = {{16{~is_unsigned & asm_word[15]}}, asm_word[15:0]};
            SZ_WORD: rdata = asm_word;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_lane_ctrl.sv
// Requester-side controller for four byte-wide banks; splits row-crossing accesses into two phases.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned accesses with an error instead of splitting them.
module dmem_lane_ctrl
    import dmem_pkg::*;
#(
    parameter int ROW_W  = DEF_ROW_W,
    parameter int ADDR_W = ROW_W + 2
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ROW_W-1:0]  bank_addr_o,
    output logic [3:0]        bank_wren_o,
    output logic [31:0]       bank_wdata_o,
    input  logic [31:0]       bank_rdata_i
);

    state_e            state_q, state_d;
    logic              we_q, uns_q, err_q;
    size_e             size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, asm_q, ext_rdata;

    size_e             req_size;
    logic [2:0]        req_n, n_q;
    logic              accept, req_bad, crossing;
    logic [1:0]        off_q;
    logic [ROW_W-1:0]  row_q;
    logic [LANES-1:0]  lane_act, lane_ph2, phase_lanes;
    logic [1:0]        lane_k [LANES];

    assign req_size    = size_e'(req_size_i);
    assign req_n       = size_bytes(req_size);
    assign req_ready_o = (state_q == IDLE);
    assign accept      = req_valid_i && req_ready_o;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign req_bad = (req_size == SZ_ILL) ||
                     ((req_addr_i[1:0] & (req_n[1:0] - 2'd1)) != 2'b00);
`else
    assign req_bad = (req_size == SZ_ILL);
`endif

    assign n_q      = size_bytes(size_q);
    assign off_q    = addr_q[1:0];
    assign row_q    = addr_q[ADDR_W-1:2];
    assign crossing = ({2'b00, off_q} + {1'b0, n_q}) > 4'd4;

    // Lane l carries data byte k = (l - off) mod 4; lanes below off belong to the next row.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_k[l]   = 2'(l) - off_q;
            lane_act[l] = {1'b0, lane_k[l]} < n_q;
            lane_ph2[l] = 2'(l) < off_q;
        end
    end

    always_comb begin
        bank_addr_o  = '0;
        bank_wren_o  = '0;
        bank_wdata_o = '0;
        phase_lanes  = '0;
        if (state_q == PH1) begin
            phase_lanes = lane_act & ~lane_ph2;
            bank_addr_o = row_q;
        end else if (state_q == PH2) begin
            phase_lanes = lane_act & lane_ph2;
            bank_addr_o = row_q + ROW_W'(1);
        end
        if (we_q) begin
            bank_wren_o = phase_lanes;
            for (int l = 0; l < LANES; l++) begin
                if (phase_lanes[l])
                    bank_wdata_o[8*l +: 8] = wdata_q[{lane_k[l], 3'b000} +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_bad ? RESP : PH1;
            PH1:     state_d = crossing ? PH2 : RESP;
            PH2:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we_i;
                uns_q   <= req_unsigned_i;
                err_q   <= req_bad;
                size_q  <= req_size;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                asm_q   <= '0;
            end else if (!we_q && (state_q == PH1 || state_q == PH2)) begin
                for (int l = 0; l < LANES; l++) begin
                    if (phase_lanes[l])
                        asm_q[{lane_k[l], 3'b000} +: 8] <= bank_rdata_i[8*l +: 8];
                end
            end
        end
    end

    dmem_load_ext u_load_ext (
        .asm_word    (asm_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rdata       (ext_rdata)
    );

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_err_o   = (state_q == RESP) && err_q;
    assign rsp_rdata_o = (state_q == RESP && !err_q && !we_q) ? ext_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Self-checking bench for dmem_lane_ctrl: byte-addressed reference model plus directed vectors.
// Honours DMEM_MISALIGN_TRAP_EN when the design is built with it.
module tb_dmem_lane_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, bank_wdata, bank_rdata;
    logic [13:0] bank_addr;
    logic [3:0]  bank_wren;

    int errors = 0;
    int checks = 0;

    logic [7:0] bmem    [0:65535];
    logic [7:0] ref_mem [0:65535];

    int unsigned cyc = 0;
    logic        m_active = 1'b0;
    int unsigned m_acc = 0;
    logic        m_we, m_uns, m_err;
    logic [1:0]  m_size;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    int          m_n, m_lat;

    logic [13:0] obs_row  [1:2];
    logic [3:0]  obs_wren [1:2];
    logic [31:0] last_rdata;
    logic        last_err;
    int          rsp_count = 0;

    dmem_lane_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .bank_addr_o    (bank_addr),
        .bank_wren_o    (bank_wren),
        .bank_wdata_o   (bank_wdata),
        .bank_rdata_i   (bank_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    assign bank_rdata = {bmem[{bank_addr, 2'd3}], bmem[{bank_addr, 2'd2}],
                         bmem[{bank_addr, 2'd1}], bmem[{bank_addr, 2'd0}]};

    // Bank writes use values that are stable for the whole cycle.
    always @(negedge clk) begin
        for (int l = 0; l < 4; l++)
            if (bank_wren[l]) bmem[{bank_addr, 2'(l)}] = bank_wdata[8*l +: 8];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected bank activity for phase p, derived from plain byte-address arithmetic.
    task automatic exp_phase(input int p, output logic [13:0] row, output logic [3:0] wren,
                             output logic [31:0] wdata);
        logic [15:0] base, a;
        base  = (p == 1) ? m_addr : m_addr + 16'd4;
        row   = base[15:2];
        wren  = '0;
        wdata = '0;
        for (int k = 0; k < m_n; k++) begin
            a = m_addr + 16'(k);
            if (m_we && (((int'(m_addr[1:0]) + k) >= 4) == (p == 2))) begin
                wren[a[1:0]] = 1'b1;
                wdata[int'(a[1:0])*8 +: 8] = m_wdata[8*k +: 8];
            end
        end
    endtask

    task automatic commit_phase(input int p);
        logic [15:0] a;
        for (int k = 0; k < m_n; k++) begin
            a = m_addr + 16'(k);
            if (m_we && (((int'(m_addr[1:0]) + k) >= 4) == (p == 2)))
                ref_mem[a] = m_wdata[8*k +: 8];
        end
    endtask

    function automatic logic [31:0] exp_rdata();
        logic [63:0] v;
        logic [15:0] a;
        v = '0;
        if (m_err || m_we) return 32'h0;
        for (int k = 0; k < m_n; k++) begin
            a = m_addr + 16'(k);
            v = v | (64'(ref_mem[a]) << (8*k));
        end
        if (!m_uns && m_n < 4 && v[8*m_n-1]) v = v - (64'd1 << (8*m_n));
        return v[31:0];
    endfunction

    always @(negedge clk) begin : compare
        int c;
        logic [13:0] er;
        logic [3:0]  ew;
        logic [31:0] ed;
        if (rsp_valid) rsp_count++;
        if (!rst) begin
            c = int'(cyc - m_acc);
            if (m_active && c < m_lat - 1) begin
                exp_phase(c + 1, er, ew, ed);
                obs_row[c+1]  = bank_addr;
                obs_wren[c+1] = bank_wren;
                checkOutput("phase_ready", 32'(ready), 32'h0);
                checkOutput("phase_rsp_valid", 32'(rsp_valid), 32'h0);
                checkOutput("phase_row", 32'(bank_addr), 32'(er));
                checkOutput("phase_wren", 32'(bank_wren), 32'(ew));
                checkOutput("phase_wdata", bank_wdata, ed);
                commit_phase(c + 1);
            end else if (m_active && c == m_lat - 1) begin
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                checkOutput("resp_ready", 32'(ready), 32'h0);
                checkOutput("resp_valid", 32'(rsp_valid), 32'h1);
                checkOutput("resp_err", 32'(rsp_err), 32'(m_err));
                checkOutput("resp_rdata", rsp_rdata, exp_rdata());
                checkOutput("resp_wren", 32'(bank_wren), 32'h0);
            end else begin
                checkOutput("idle_ready", 32'(ready), 32'h1);
                checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'h0);
                checkOutput("idle_wren", 32'(bank_wren), 32'h0);
            end
        end
    end

    task automatic setModel(input logic we, input logic [1:0] size, input logic uns,
                            input logic [15:0] addr, input logic [31:0] wdata);
        m_we = we; m_size = size; m_uns = uns; m_addr = addr; m_wdata = wdata;
        case (size)
            2'd0: m_n = 1;
            2'd1: m_n = 2;
            2'd2: m_n = 4;
            default: m_n = 0;
        endcase
        m_err = (size == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (m_n != 0 && (int'(addr) % m_n) != 0) m_err = 1'b1;
`endif
        if (m_err) m_lat = 1;
        else if (int'(addr[1:0]) + m_n > 4) m_lat = 3;
        else m_lat = 2;
        m_acc    = cyc;
        m_active = 1'b1;
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [15:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        obs_row[1] = 14'h1555; obs_row[2] = 14'h1555;
        obs_wren[1] = 4'h0; obs_wren[2] = 4'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        setModel(we, size, uns, addr, wdata);
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [15:0] addr, input logic [31:0] wdata);
        drive(we, size, uns, addr, wdata);
        repeat (m_lat) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int saved_rsp;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        last_rdata = '0; last_err = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            bmem[i]    = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rst_ready", 32'(ready), 32'h1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'h0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_wren", 32'(bank_wren), 32'h0);
        checkOutput("rst_bank_addr", 32'(bank_addr), 32'h0);
        checkOutput("rst_bank_wdata", bank_wdata, 32'h0);

        applyStimulus(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF);
        checkOutput("sw_row", 32'(obs_row[1]), 32'd4);
        checkOutput("sw_wren", 32'(obs_wren[1]), 32'hF);
        checkOutput("sw_rdata", last_rdata, 32'h0);
        applyStimulus(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
        checkOutput("lw_rdata", last_rdata, 32'hDEADBEEF);
        applyStimulus(1'b0, 2'd1, 1'b0, 16'h0012, 32'h0);
        checkOutput("lh_signed", last_rdata, 32'hFFFFDEAD);

        applyStimulus(1'b1, 2'd0, 1'b0, 16'h0103, 32'h00000080);
        checkOutput("sb_wren", 32'(obs_wren[1]), 32'h8);
        applyStimulus(1'b0, 2'd0, 1'b0, 16'h0103, 32'h0);
        checkOutput("lb_signed", last_rdata, 32'hFFFFFF80);
        applyStimulus(1'b0, 2'd0, 1'b1, 16'h0103, 32'h0);
        checkOutput("lb_unsigned", last_rdata, 32'h00000080);

        applyStimulus(1'b1, 2'd2, 1'b0, 16'h0006, 32'h11223344);
`ifdef DMEM_MISALIGN_TRAP_EN
        checkOutput("xw_trap_err", 32'(last_err), 32'h1);
`else
        checkOutput("xw_ph1_row", 32'(obs_row[1]), 32'd1);
        checkOutput("xw_ph1_wren", 32'(obs_wren[1]), 32'hC);
        checkOutput("xw_ph2_row", 32'(obs_row[2]), 32'd2);
        checkOutput("xw_ph2_wren", 32'(obs_wren[2]), 32'h3);
        checkOutput("xw_mem", {bmem[9], bmem[8], bmem[7], bmem[6]}, 32'h11223344);
        applyStimulus(1'b0, 2'd2, 1'b0, 16'h0006, 32'h0);
        checkOutput("xw_load", last_rdata, 32'h11223344);
`endif

        applyStimulus(1'b1, 2'd1, 1'b0, 16'hFFFF, 32'h0000A55A);
`ifdef DMEM_MISALIGN_TRAP_EN
        checkOutput("wrap_trap_err", 32'(last_err), 32'h1);
        checkOutput("wrap_trap_mem", 32'(bmem[16'hFFFF]), 32'hFC);
`else
        checkOutput("wrap_ph1_row", 32'(obs_row[1]), 32'd16383);
        checkOutput("wrap_ph2_row", 32'(obs_row[2]), 32'd0);
        checkOutput("wrap_lane3", 32'(bmem[16'hFFFF]), 32'h5A);
        checkOutput("wrap_lane0", 32'(bmem[0]), 32'hA5);
        applyStimulus(1'b0, 2'd1, 1'b0, 16'hFFFF, 32'h0);
        checkOutput("wrap_load", last_rdata, 32'hFFFFA55A);
`endif

        applyStimulus(1'b1, 2'd3, 1'b0, 16'h0020, 32'h12345678);
        checkOutput("ill_err", 32'(last_err), 32'h1);
        checkOutput("ill_rdata", last_rdata, 32'h0);
        checkOutput("ill_mem", 32'(bmem[16'h0020]), 32'hE3);
        applyStimulus(1'b0, 2'd3, 1'b1, 16'h0010, 32'h0);
        checkOutput("ill_load_rdata", last_rdata, 32'h0);

        // Reset lands during PH1 of a crossing store; the second-row half must never be written.
        saved_rsp = rsp_count;
        drive(1'b1, 2'd2, 1'b0, 16'h0206, 32'hCAFEF00D);
        @(negedge clk); #1;
        rst = 1'b1;
        m_active = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_mid_ready", 32'(ready), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_mid_ph2_b0", 32'(bmem[16'h0208]), 32'h3B);
        checkOutput("rst_mid_ph2_b1", 32'(bmem[16'h0209]), 32'h42);
`ifndef DMEM_MISALIGN_TRAP_EN
        checkOutput("rst_mid_no_rsp", rsp_count, saved_rsp);
        applyStimulus(1'b0, 2'd2, 1'b0, 16'h0206, 32'h0);
        checkOutput("rst_mid_load", last_rdata, 32'h423BF00D);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
